// File: rtl/ysyx_040066_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip register port plus the trap
// request handshake toward the CSR unit.
module ysyx_040066_clint #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned AW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [63:0]   req_wdata,
    input  logic [7:0]    req_wmask,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [63:0]   resp_rdata,
    output logic          resp_err,
    input  logic [63:0]   mie,
    input  logic [63:0]   mstatus,
    output logic          intr_valid,
    output logic [63:0]   intr_no,
    input  logic          intr_ack,
    output logic          mtip,
    output logic          msip_o
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NBYTE = XLEN / 8;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [AW-1:0]   ADDR_MSIP  = AW'(16'h0000);
    localparam logic [AW-1:0]   ADDR_CMP   = AW'(16'h4000);
    localparam logic [AW-1:0]   ADDR_MTIME = AW'(16'hBFF8);
    localparam logic [XLEN-1:0] CAUSE_MSI  = 64'h8000_0000_0000_0003;
    localparam logic [XLEN-1:0] CAUSE_MTI  = 64'h8000_0000_0000_0007;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    typedef enum logic [1:0] {
        INT_IDLE = 2'b00,
        INT_PEND = 2'b01,
        INT_WAIT = 2'b10
    } int_state_e;

    bus_state_e       bus_state, bus_state_d;
    int_state_e       int_state, int_state_d;
    logic [XLEN-1:0]  mtime, mtimecmp;
    logic [DIV_W-1:0] div_cnt;
    logic             msip_bit;
    logic             hit_msip, hit_cmp, hit_mtime, mapped, accept, wr;
    logic             tick, en, latch;
    logic [XLEN-1:0]  rdata_c, cause_c;
    logic             unused_bits;

    // Byte-enable merge of write data into an existing register value
    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] data,
                                              input logic [NBYTE-1:0] mask);
        logic [XLEN-1:0] res;
        res = old;
        for (int i = 0; i < int'(NBYTE); i++) begin
            if (mask[i]) res[i*8 +: 8] = data[i*8 +: 8];
        end
        return res;
    endfunction

    // Misaligned offsets never match a register, so they fall into the error path
    assign hit_msip  = (req_addr == ADDR_MSIP);
    assign hit_cmp   = (req_addr == ADDR_CMP);
    assign hit_mtime = (req_addr == ADDR_MTIME);
    assign mapped    = hit_msip | hit_cmp | hit_mtime;
    assign accept    = req_valid && (bus_state == BUS_IDLE);
    assign wr        = accept && req_wen;
    assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_comb begin
        rdata_c = '0;
        if (hit_msip)       rdata_c = {63'b0, msip_bit};
        else if (hit_cmp)   rdata_c = mtimecmp;
        else if (hit_mtime) rdata_c = mtime;
    end

    always_comb begin
        bus_state_d = bus_state;
        case (bus_state)
            BUS_IDLE: if (req_valid)  bus_state_d = BUS_RESP;
            BUS_RESP: if (resp_ready) bus_state_d = BUS_IDLE;
            default:                  bus_state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state  <= BUS_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            bus_state <= bus_state_d;
            if (accept) begin
                resp_rdata <= (req_wen || !mapped) ? '0 : rdata_c;
                resp_err   <= !mapped;
            end
        end
    end

    assign req_ready  = (bus_state == BUS_IDLE);
    assign resp_valid = (bus_state == BUS_RESP);

    // Timebase and registers; a bus write to mtime overrides the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip_bit <= 1'b0;
            div_cnt  <= '0;
            mtip     <= 1'b0;
        end else begin
            if (wr && hit_mtime) begin
                mtime   <= merge(mtime, req_wdata, req_wmask);
                div_cnt <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) mtime <= mtime + XLEN'(1);
            end
            if (wr && hit_cmp) mtimecmp <= merge(mtimecmp, req_wdata, req_wmask);
            if (wr && hit_msip && req_wmask[0]) msip_bit <= req_wdata[0];
            mtip <= (mtime >= mtimecmp);
        end
    end

    assign msip_o = msip_bit;

    assign en      = mstatus[3] & ((msip_bit & mie[3]) | (mtip & mie[7]));
    assign cause_c = (msip_bit & mie[3]) ? CAUSE_MSI : CAUSE_MTI;

    always_comb begin
        int_state_d = int_state;
        latch       = 1'b0;
        case (int_state)
            INT_IDLE: begin
                if (en) begin
                    int_state_d = INT_PEND;
                    latch       = 1'b1;
                end
            end
            INT_PEND: begin
                if (intr_ack)  int_state_d = INT_WAIT;
                else if (!en)  int_state_d = INT_IDLE;
            end
            INT_WAIT: int_state_d = INT_IDLE;
            default:  int_state_d = INT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_state <= INT_IDLE;
            intr_no   <= '0;
        end else begin
            int_state <= int_state_d;
            if (latch) intr_no <= cause_c;
        end
    end

    assign intr_valid = (int_state == INT_PEND);

    assign unused_bits = ^{mie[63:8], mie[6:4], mie[2:0], mstatus[63:4], mstatus[2:0]};

endmodule

// File: doc/ysyx_040066_clint.md
# ysyx_040066_clint

Core-local interruptor for the ysyx_040066 core: holds `mtime`, `mtimecmp` and `msip` behind a small memory-mapped register port. It is the initiating end of the trap interface into the CSR unit. It gates pending timer and software interrupts with the CSR's `mie` and `mstatus`, presents one interrupt request with its cause code, and holds that request until the core acknowledges trap entry.

## Interface
Parameters:
- `TICK_DIV`, default 1: core cycles per `mtime` increment; legal values are ≥1.
- `AW`, default 16: register-port address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: register access request.
- `req_ready` out 1: port can accept a request.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in AW: byte offset within the block.
- `req_wdata` in 64: write data.
- `req_wmask` in 8: byte enables for writes.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 64: read data; 0 for writes and errors.
- `resp_err` out 1: unmapped or misaligned access.
- `mie` in 64: CSR `mie`; bit 3 = MSIE, bit 7 = MTIE.
- `mstatus` in 64: CSR `mstatus`; bit 3 = MIE.
- `intr_valid` out 1: interrupt request to the trap logic.
- `intr_no` out 64: cause code for the CSR's `NO` input.
- `intr_ack` in 1: core takes the trap this cycle.
- `mtip` out 1: timer-pending level, mirrored into `mip[7]`.
- `msip_o` out 1: software-pending level, mirrored into `mip[3]`.

## Operation
Register map. The port is 64-bit only; `req_addr[2:0]` must be 0, otherwise the access errors.
- 0x0000 `msip`:
  - Bit 0 is read/write.
  - Bits 63:1 read as 0.
  - Bit 0 is written only when `req_wmask[0]`=1.
- 0x4000 `mtimecmp`: 64-bit read/write, written per byte.
- 0xBFF8 `mtime`: 64-bit read/write, written per byte.
- Any other address: `resp_err`=1, `resp_rdata`=0, no state change.

Bus FSM:
- IDLE (`req_ready`=1): on `req_valid`, perform the read or write and go to RESP.
  - Read data is sampled in the accept cycle, before that cycle's `mtime` increment.
- RESP (`req_ready`=0, `resp_valid`=1): outputs stay stable until `resp_ready`, then go to IDLE.

Timebase:
- `div_cnt` counts 0..TICK_DIV-1. On the wrap to 0, `mtime` increments by 1.
- `mtime` arithmetic is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A bus write to `mtime` takes precedence over the increment in the same cycle and clears `div_cnt`.

Pending levels:
- `mtip` is registered: next `mtip` = (`mtime` ≥ `mtimecmp`), unsigned, using current register values.
- `msip_o` = `msip[0]`.

Interrupt FSM:
- IDLE:
  - Enable condition `en` = `mstatus[3]` & ((`msip_o` & `mie[3]`) | (`mtip` & `mie[7]`)).
  - When `en` is true, latch the cause and go to PEND.
  - Software has priority over timer: cause is 0x8000_0000_0000_0003 if (`msip_o` & `mie[3]`), else 0x8000_0000_0000_0007.
- PEND (`intr_valid`=1):
  - `intr_no` holds the latched cause for the whole state.
  - `intr_ack` goes to WAIT.
  - If `en` drops without ack, return to IDLE (withdrawal). Ack has priority when both occur in the same cycle.
- WAIT (`intr_valid`=0): one cycle, which lets the CSR clear `mstatus.MIE`, then go to IDLE.
- The handler clears the source (write `msip`=0 or raise `mtimecmp`); the block never clears pending state itself.

## Timing
Reset values:
- `mtime`=0, `mtimecmp`=all ones, `msip`=0, `div_cnt`=0.
- `mtip`=0, `msip_o`=0.
- `intr_valid`=0, `intr_no`=0.
- Bus FSM in IDLE: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Interrupt FSM in IDLE.

Latencies:
- Request accepted in cycle N → `resp_valid` in N+1.
- Minimum spacing between accepted requests is 2 cycles.
- `mtime` reaches `mtimecmp` in cycle N → `mtip`=1 in N+1 → `intr_valid`=1 in N+2, if enabled.
- `msip` written 1 in cycle N → `msip_o`=1 in N+1 → `intr_valid`=1 in N+2, if enabled.
- `intr_ack` in cycle N → `intr_valid`=0 in N+1 (WAIT) → earliest re-request in N+3.

Reset asserted mid-operation: all FSMs return to IDLE on the next edge; an outstanding response is dropped and an outstanding interrupt request is withdrawn.

## Test plan
- Reset, then read 0xBFF8 and 0x4000 → `mtime` ≈ cycles since reset (exact with TICK_DIV=1), `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `resp_err`=0.
- `mstatus`=0x8, `mie`=0x80; write `mtimecmp`=100 with TICK_DIV=1 → `mtip` rises in the cycle after `mtime`=100, `intr_valid` one cycle later with `intr_no`=0x8000_0000_0000_0007. Hold `intr_ack`=1 for one cycle → `intr_valid`=0.
- `mie`=0x88, `msip`=1 and timer pending together → `intr_no`=0x8000_0000_0000_0003. After ack plus a write `msip`=0, the next request carries cause 7.
- In PEND, drop `mie[7]` with no ack → `intr_valid`=0 next cycle; with ack and withdrawal in the same cycle, the FSM goes to WAIT.
- Byte-masked write `req_wmask`=0x0F, data 0x1122_3344_5566_7788 to `mtimecmp` (all ones) → reads 0xFFFF_FFFF_5566_7788. Read at 0x0004 or 0x1000 → `resp_err`=1, `resp_rdata`=0.
- Write `mtime`=0xFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 → wraps to 0 two cycles later. Hold `resp_ready`=0 for 5 cycles → response stays stable and `req_ready`=0 throughout.
